// File: rtl/trojan_trig_gen_if.sv
`default_nettype none
// ============================================================================
// trojan_trig_gen_if : control/trigger bundle between test control and the
//                      trigger sequence generator.
// Rev 1.0
// ============================================================================
interface trojan_trig_gen_if #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int TRIG_W  = 32,
  parameter int GAP_W   = 4
) ();
  logic                     start;
  logic [MAX_LEN*SYM_W-1:0] seq_in;
  logic [3:0]               seq_len;
  logic [GAP_W-1:0]         gap;
  logic [SYM_W-1:0]         idle_sym;
  logic [TRIG_W-1:0]        trigger;
  logic                     sym_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, seq_in, seq_len, gap, idle_sym,
    input  trigger, sym_valid, busy, done
  );

  modport slave (
    input  start, seq_in, seq_len, gap, idle_sym,
    output trigger, sym_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/trojan_trig_gen.sv
`default_nettype none
// ============================================================================
// trojan_trig_gen : drives the trigger bus with a programmable sequence of
//                   symbols, one per clock, with optional idle gaps.
// Rev 1.0
// ============================================================================
module trojan_trig_gen #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int TRIG_W  = 32,
  parameter int GAP_W   = 4,
  parameter logic [TRIG_W-SYM_W-1:0] FILL = '0
) (
  input  logic             clk,
  input  logic             rst,
  trojan_trig_gen_if.slave tg
);

  localparam int SEQ_W = MAX_LEN * SYM_W;
  localparam int LEN_W = 4;
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [GAP_W-1:0] c_gap_one = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  // Remaining symbols, next one always at the top.
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic [SYM_W-1:0]  idle_q, idle_d;
  logic [SYM_W-1:0]  sym_d;
  logic [TRIG_W-1:0] trig_q;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  w_len_clamp;

  assign w_len_clamp = (tg.seq_len > c_max_len) ? c_max_len : tg.seq_len;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    sym_d   = tg.idle_sym;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      // The done cycle doubles as an accept slot, so a held start repeats
      // the sequence with exactly one done cycle between runs.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (tg.start) begin
          len_d  = w_len_clamp;
          gap_d  = tg.gap;
          idle_d = tg.idle_sym;
          idx_d  = '0;
          cnt_d  = '0;
          if (w_len_clamp == '0) begin
            seq_d   = tg.seq_in;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            seq_d   = tg.seq_in << SYM_W;
            sym_d   = tg.seq_in[SEQ_W-1 -: SYM_W];
            state_d = S_SEND;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (idx_q == len_q - c_len_one) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          seq_d   = seq_q << SYM_W;
          sym_d   = seq_q[SEQ_W-1 -: SYM_W];
          idx_d   = idx_q + c_len_one;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = gap_q;
          sym_d   = idle_q;
          busy_d  = 1'b1;
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (cnt_q <= c_gap_one) begin
          state_d = S_SEND;
          cnt_d   = '0;
          seq_d   = seq_q << SYM_W;
          sym_d   = seq_q[SEQ_W-1 -: SYM_W];
          idx_d   = idx_q + c_len_one;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - c_gap_one;
          sym_d = idle_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      trig_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      trig_q  <= {FILL, sym_d};
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tg.trigger   = trig_q;
  assign tg.sym_valid = valid_q;
  assign tg.busy      = busy_q;
  assign tg.done      = done_q;

`ifndef SYNTHESIS
  a_done_not_busy : assert property (@(posedge clk) disable iff (rst) !(done_q && busy_q));
  a_valid_in_busy : assert property (@(posedge clk) disable iff (rst) valid_q |-> busy_q);
`endif

endmodule
`default_nettype wire
